iterative_circular_rotator_ctrl: RTL

//   Multi-cycle controller that circularly rotates an N-bit word left or right by a
//   run-time amount. It reuses one rotate stage, sequenced by an FSM: one stage per

---
 rtl/iterative_circular_rotator_ctrl.sv | 132 +++++++++++++
 1 files changed

// File: rtl/iterative_circular_rotator_ctrl.sv
// Iterative circular rotator: one reusable rotate stage per cycle, covering bit cnt of the amount.
// Valid/ready on both sides; the result is held in a register until the consumer takes it.
module iterative_circular_rotator_ctrl #(
  parameter  int N = 8,
  localparam int W = $clog2(N)
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic [N-1:0] in_data,
  input  logic [W-1:0] in_amt,
  input  logic         in_dir,
  output logic         out_valid,
  input  logic         out_ready,
  output logic [N-1:0] out_data,
  output logic         busy
);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ROTATE = 2'd1,
    DONE   = 2'd2
  } state_t;

  localparam logic [W-1:0] CNT_ONE  = W'(32'd1);
  localparam logic [W-1:0] CNT_LAST = W'(W - 1);

  state_t         state_r, state_s;
  logic [N-1:0]   data_r, data_s;
  logic [W-1:0]   amt_r, amt_s;
  logic           dir_r, dir_s;
  logic [W-1:0]   cnt_r, cnt_s;
  logic [N-1:0]   out_data_r, out_data_s;
  logic           out_valid_r, out_valid_s;
  int unsigned    stage_amt_s;

  // Single rotate stage; r = 0 bypasses so a shift by N is never formed.
  function automatic logic [N-1:0] rotate_stage(input logic [N-1:0] x,
                                                input int unsigned r,
                                                input logic dir);
    logic [N-1:0] res;
    if (r == 32'd0) begin
      res = x;
    end else if (dir == 1'b0) begin
      res = (x << r) | (x >> (N - r));
    end else begin
      res = (x >> r) | (x << (N - r));
    end
    return res;
  endfunction

  assign in_ready  = (state_r == IDLE);
  assign busy      = (state_r != IDLE);
  assign out_valid = out_valid_r;
  assign out_data  = out_data_r;

  // Next-state and datapath update for the sequencer.
  always_comb begin
    state_s     = state_r;
    data_s      = data_r;
    amt_s       = amt_r;
    dir_s       = dir_r;
    cnt_s       = cnt_r;
    out_data_s  = out_data_r;
    out_valid_s = out_valid_r;
    stage_amt_s = (32'd1 << cnt_r) % N;
    case (state_r)
      IDLE: begin
        if (in_valid) begin
          data_s  = in_data;
          amt_s   = in_amt;
          dir_s   = in_dir;
          cnt_s   = '0;
          state_s = ROTATE;
        end else begin
          state_s = IDLE;
        end
      end
      ROTATE: begin
        if (amt_r[cnt_r]) begin
          data_s = rotate_stage(data_r, stage_amt_s, dir_r);
        end else begin
          data_s = data_r;
        end
        cnt_s = cnt_r + CNT_ONE;
        // Result is captured on the same edge that finishes the last stage.
        if (cnt_r == CNT_LAST) begin
          state_s     = DONE;
          out_valid_s = 1'b1;
          out_data_s  = data_s;
        end else begin
          state_s = ROTATE;
        end
      end
      DONE: begin
        if (out_ready) begin
          state_s     = IDLE;
          out_valid_s = 1'b0;
        end else begin
          state_s = DONE;
        end
      end
      default: begin
        state_s     = IDLE;
        out_valid_s = 1'b0;
      end
    endcase
  end

  // State and datapath registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r     <= IDLE;
      data_r      <= '0;
      amt_r       <= '0;
      dir_r       <= 1'b0;
      cnt_r       <= '0;
      out_data_r  <= '0;
      out_valid_r <= 1'b0;
    end else begin
      state_r     <= state_s;
      data_r      <= data_s;
      amt_r       <= amt_s;
      dir_r       <= dir_s;
      cnt_r       <= cnt_s;
      out_data_r  <= out_data_s;
      out_valid_r <= out_valid_s;
    end
  end

endmodule
